seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, meaning the maximum pattern length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the match counter width.
REQ-003 The block SHALL have parameter DEF_PATTERN, default 8'b0000_1010, meaning the pattern loaded at reset.
REQ-004 The block SHALL have parameter DEF_LEN, default 4, meaning the pattern length loaded at reset.
REQ-005 The block SHALL have parameter DEF_OVERLAP, default 1, meaning the overlap mode loaded at reset.
REQ-006 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-007 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-008 The block SHALL have port in_valid  input  1  in_bit is valid this cycle.
REQ-009 The block SHALL have port in_bit  input  1  serial input bit.
REQ-010 The block SHALL have port cfg_load  input  1  one-cycle strobe that loads a new configuration.
REQ-011 The block SHALL have port cfg_pattern  input  MAX_LEN  new pattern; bit [len-1] is the first bit received and bit [0] the last.
REQ-012 The block SHALL have port cfg_len  input  $clog2(MAX_LEN)+1  new pattern length.
REQ-013 The block SHALL have port cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-014 The block SHALL have port cnt_clr  input  1  synchronous clear of match_count.
REQ-015 The block SHALL have port match  output  1  registered one-cycle detection pulse.
REQ-016 The block SHALL have port match_count  output  CNT_W  saturating count of matches.
REQ-017 The block SHALL have port cfg_err  output  1  last cfg_load was illegal.

Function
REQ-018 The block SHALL keep a MAX_LEN-bit history shift register and a fill counter; both update only on edges where in_valid=1 and the state is ST_RUN.
REQ-019 The fill counter SHALL count accepted bits and saturate at MAX_LEN.
REQ-020 match SHALL assert when fill>=len and the last len history bits equal pattern[len-1:0]; it asserts at the edge that samples the final bit and stays high for exactly one cycle.
REQ-021 In overlapping mode, history and fill SHALL be unaffected by a match.
REQ-022 In non-overlapping mode, fill SHALL reset to 0 on a match, so the next match needs len fresh bits.
REQ-023 When in_valid=0, match SHALL be 0 and history and fill SHALL hold.
REQ-024 The state machine SHALL have two states, ST_RUN and ST_IDLE; in ST_IDLE the block detects nothing and match stays 0.
REQ-025 A legal cfg_load (2<=cfg_len<=MAX_LEN) SHALL latch pattern, len and overlap, clear history and fill, clear cfg_err, and enter ST_RUN.
REQ-026 An illegal cfg_load SHALL set cfg_err, enter ST_IDLE and keep the old configuration latched.
REQ-027 When cfg_load and in_valid are high in the same cycle, cfg_load SHALL take priority, the bit SHALL be dropped, and match SHALL be 0.
REQ-028 match_count SHALL increment by 1 on each match and saturate at all-ones.
REQ-029 When cnt_clr and match occur in the same cycle, cnt_clr SHALL win and match_count SHALL become 0.
REQ-030 cfg_load SHALL NOT affect match_count.

Reset
REQ-031 On rst=1, asynchronously: match=0, match_count=0, cfg_err=0, history=0, fill=0, state=ST_RUN, and the configuration SHALL be loaded from DEF_PATTERN, DEF_LEN and DEF_OVERLAP.
REQ-032 With default parameters, the post-reset behaviour SHALL be an overlapping 1010 Moore detector.
REQ-033 Reset asserted mid-pattern SHALL discard partial progress; a pattern straddling the reset SHALL NOT match.

Structure
REQ-034 The package seq_det_pkg SHALL hold the state enum (ST_IDLE, ST_RUN) and a length-width helper constant function.
REQ-035 The block SHALL contain one sub-module, seq_det_window, which implements the history, the fill counter and the masked compare, and outputs hit combinationally.
REQ-036 The top level SHALL hold the configuration registers, the state machine, the match register and the counter.

Verification
REQ-037 Default config, stream 1,0,1,0,1,0 -> match pulses after bits 4 and 6; match_count=2.
REQ-038 Load pattern 1010 with overlap=0, stream 1,0,1,0,1,0 -> a single match after bit 4; match_count increments by 1.
REQ-039 Load cfg_len=9 with MAX_LEN=8 -> cfg_err=1, no matches on any stream; a following legal load clears cfg_err.
REQ-040 Load 3'b111 with len=3 and overlap=1, stream 1,1,1,1,1 with in_valid gaps between bits -> 3 matches; match=0 during the gaps.
REQ-041 With CNT_W=2, 5 matches -> match_count saturates at 3; cnt_clr in the same cycle as a match -> match_count=0.
REQ-042 Assert rst after 1,0,1, then send 0 -> no match; match_count=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parameterised serial sequence detector.
package seq_det_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Width needed to hold a length value in the range 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// Bit history, fill counter and masked compare against the active pattern.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               overlap,
  input  logic               in_bit,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] history_reg;
  logic [MAX_LEN-1:0] history_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_reg;
  logic [LEN_W-1:0]   fill_inc;

  // Only the newest len bits take part in the compare.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign mask[gi] = (LEN_W'(gi) < len);
    end
  endgenerate

  // Hit is evaluated on the post-shift view so the match lands on the sampling edge.
  always_comb begin
    history_next = {history_reg[MAX_LEN-2:0], in_bit};
    fill_inc     = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + LEN_W'(1);
    hit          = shift_en && (fill_inc >= len) &&
                   ((history_next & mask) == (pattern & mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history_reg <= '0;
      fill_reg    <= '0;
    end else if (clear) begin
      history_reg <= '0;
      fill_reg    <= '0;
    end else if (shift_en) begin
      history_reg <= history_next;
      fill_reg    <= (hit && !overlap) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with match pulse and saturating count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               MAX_LEN     = 8,
  parameter int               CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1010,
  parameter int               DEF_LEN     = 4,
  parameter logic             DEF_OVERLAP = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_bit,
  input  logic                          cfg_load,
  input  logic [MAX_LEN-1:0]            cfg_pattern,
  input  logic [len_width(MAX_LEN)-1:0] cfg_len,
  input  logic                          cfg_overlap,
  input  logic                          cnt_clr,
  output logic                          match,
  output logic [CNT_W-1:0]              match_count,
  output logic                          cfg_err
);

  localparam int               LEN_W   = len_width(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_DEF = LEN_W'(DEF_LEN);

  state_t             state_reg;
  state_t             state_next;
  logic [MAX_LEN-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic               cfg_err_reg;
  logic               match_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               cfg_legal;
  logic               load_ok;
  logic               run;
  logic               shift_en;
  logic               hit;

  assign cfg_legal = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
  assign load_ok   = cfg_load && cfg_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (cfg_load) state_next = cfg_legal ? ST_RUN : ST_IDLE;
  end

  // A load in the same cycle as a valid bit drops that bit.
  always_comb begin
    run      = (state_reg == ST_RUN);
    shift_en = run && in_valid && !cfg_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_reg <= DEF_PATTERN;
      len_reg     <= LEN_DEF;
      overlap_reg <= DEF_OVERLAP;
      cfg_err_reg <= 1'b0;
    end else if (cfg_load) begin
      cfg_err_reg <= !cfg_legal;
      if (cfg_legal) begin
        pattern_reg <= cfg_pattern;
        len_reg     <= cfg_len;
        overlap_reg <= cfg_overlap;
      end
    end
  end

  seq_det_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clear    (load_ok),
    .overlap  (overlap_reg),
    .in_bit   (in_bit),
    .pattern  (pattern_reg),
    .len      (len_reg),
    .hit      (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      match_reg <= hit;
      if (cnt_clr)                 count_reg <= '0;
      else if (hit && !(&count_reg)) count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign match       = match_reg;
  assign match_count = count_reg;
  assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed scoreboard bench for seq_detector_param (CNT_W=2 to reach saturation quickly).
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  logic exp_q[$];

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .match       (match),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the expected match is queued now and checked after the edge.
  task automatic step(input logic v, input logic b, input logic clr, input logic exp_m);
    logic e;
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    cnt_clr  = clr;
    exp_q.push_back(exp_m);
    if (clr) exp_cnt = 0;
    else if (exp_m && exp_cnt < 3) exp_cnt++;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("match", {31'd0, match}, {31'd0, e});
    $display("[TB] t=%0t valid=%0b bit=%0b clr=%0b match=%0b count=%0d", $time, v, b, clr, match, match_count);
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic ov,
                      input logic v, input logic b);
    @(negedge clk);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    in_valid    = v;
    in_bit      = b;
    @(posedge clk);
    #1;
    check("load_match", {31'd0, match}, 32'd0);
    $display("[TB] t=%0t load pattern=%0h len=%0d ov=%0b err=%0b", $time, p, l, ov, cfg_err);
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_cnt(input string tag);
    check(tag, {30'd0, match_count}, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_match", {31'd0, match}, 32'd0);
    check("rst_count", {30'd0, match_count}, 32'd0);
    check("rst_err", {31'd0, cfg_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Default config: overlapping 1010.
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    step(1, 0, 0, 1); step(1, 1, 0, 0); step(1, 0, 0, 1);
    check_cnt("default_count");
    step(0, 0, 1, 0);
    check_cnt("clr_count");

    // Non-overlapping 1010: the next match needs four fresh bits.
    load(8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b0);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    step(1, 0, 0, 1); step(1, 1, 0, 0); step(1, 0, 0, 0);
    check_cnt("nonovl_count1");
    step(1, 1, 0, 0); step(1, 0, 0, 1);
    check_cnt("nonovl_count2");
    step(0, 0, 1, 0);

    // 111 overlapping, load coincides with a valid 1 that must be dropped; gaps between bits.
    load(8'b0000_0111, 4'd3, 1'b1, 1'b1, 1'b1);
    step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 1); step(0, 1, 0, 0); step(1, 1, 0, 1); step(0, 1, 0, 0);
    step(1, 1, 0, 1);
    check_cnt("gap_count3");
    step(1, 1, 0, 1); step(1, 1, 0, 1);
    check_cnt("sat_count");
    step(1, 1, 1, 1);
    check_cnt("clr_beats_match");

    // Illegal length: error flag, idle, old config kept but unused.
    load(8'b0000_0111, 4'd9, 1'b1, 1'b0, 1'b0);
    check("err_len9", {31'd0, cfg_err}, 32'd1);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    check_cnt("idle_count");
    load(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0);
    check("err_cleared", {31'd0, cfg_err}, 32'd0);
    load(8'b0000_0011, 4'd1, 1'b1, 1'b0, 1'b0);
    check("err_len1", {31'd0, cfg_err}, 32'd1);

    // Full-width pattern at MAX_LEN.
    load(8'b1100_1010, 4'd8, 1'b1, 1'b0, 1'b0);
    check("err_len8", {31'd0, cfg_err}, 32'd0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 1);
    check_cnt("len8_count");

    // Async reset mid-pattern discards progress and restores defaults.
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    exp_cnt = 0;
    check("async_rst_count", {30'd0, match_count}, 32'd0);
    check("async_rst_match", {31'd0, match}, 32'd0);
    #1;
    rst = 1'b0;
    step(1, 0, 0, 0);
    check_cnt("post_rst_count");
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 1);
    check_cnt("post_rst_default");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
